mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 117 +++++++++++
 tb/tb_mdu_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over a 64-bit work register, with HI/LO result registers.
module mdu_iter (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    typedef struct packed {
        logic        is_div;
        logic        neg_lo;   // negate quotient / whole product
        logic        neg_hi;   // negate remainder
        logic        dz;       // divide by zero
        logic [31:0] a_raw;
        logic [31:0] mc;       // multiplicand or divisor magnitude
    } req_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] w;
    req_t        rq;

    logic        sgn;
    logic [31:0] ma, mb;
    logic [32:0] mul_sum;
    logic [32:0] rem33;
    logic        ge;
    logic [31:0] diff;

    assign sgn = ~op[0];
    assign ma  = (sgn && a[31]) ? -a : a;
    assign mb  = (sgn && b[31]) ? -b : b;

    assign mul_sum = {1'b0, w[63:32]} + (w[0] ? {1'b0, rq.mc} : 33'd0);
    assign rem33   = {w[63:32], w[31]};
    assign ge      = rem33 >= {1'b0, rq.mc};
    // Fits in 32 bits whenever ge holds, since the partial remainder stays below the divisor.
    assign diff    = rem33[31:0] - rq.mc;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)         state_nx = CALC;
            CALC:    if (cnt == 5'd31)  state_nx = FIX;
            FIX:     if (cnt == 5'd1)   state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt  <= '0;
            w    <= '0;
            rq   <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt       <= '0;
                    w         <= {32'd0, ma};
                    rq.mc     <= mb;
                    rq.a_raw  <= a;
                    rq.is_div <= op[1];
                    rq.neg_lo <= sgn && (a[31] ^ b[31]);
                    rq.neg_hi <= sgn && op[1] && a[31];
                    rq.dz     <= op[1] && (b == 32'd0);
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (!rq.is_div) w <= {mul_sum, w[31:1]};
                    else if (ge)    w <= {diff, w[30:0], 1'b1};
                    else            w <= {rem33[31:0], w[30:0], 1'b0};
                end
                FIX: begin
                    // First FIX cycle applies the sign fix-up, second publishes HI/LO.
                    if (cnt == 5'd0) begin
                        cnt <= 5'd1;
                        if (!rq.is_div) begin
                            if (rq.neg_lo) w <= -w;
                        end else if (rq.dz) begin
                            w <= {rq.a_raw, 32'hFFFF_FFFF};
                        end else begin
                            w <= {rq.neg_hi ? -w[63:32] : w[63:32],
                                  rq.neg_lo ? -w[31:0]  : w[31:0]};
                        end
                    end else begin
                        cnt  <= '0;
                        hi   <= w[63:32];
                        lo   <= w[31:0];
                        done <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        start;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    mdu_iter dut (
        .clk(clk), .clrn(clrn), .a(a), .b(b), .op(op), .start(start),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic signed [31:0] qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        qx = x;
        qy = y;
        case (o)
            2'b00: return sx * sy;
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(qx % qy), 32'(qx / qy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Launch one op, scramble inputs after capture, wait for done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] res, output int lat, output logic bsy);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {hi, lo};
        bsy = busy;
    endtask

    task automatic test_reset;
        clrn = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
        #3;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        #14 clrn = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  o[6]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] xa[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] yb[6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] ex[6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
                               64'h0000_0002_0000_000E, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_8000_0000};
        logic [63:0] res;
        int lat;
        logic bsy;
        for (int i = 0; i < 6; i++) begin
            do_op(o[i], xa[i], yb[i], res, lat, bsy);
            checks++;
            if (res !== ex[i] || lat != 34 || bsy !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d: hi:lo=%h lat=%0d busy=%b, expected %h lat=34 busy=0", i, res, lat, bsy, ex[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] res;
        int lat;
        logic bsy;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            if (i % 6 == 1) y = 32'd0;
            if (i % 6 == 2) y = $urandom_range(1, 20);
            if (i % 6 == 3) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (i % 6 == 4) y = -$urandom_range(1, 20);
            do_op(o, x, y, res, lat, bsy);
            checks++;
            if (res !== model(o, x, y) || lat != 34) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: hi:lo=%h lat=%0d, expected %h lat=34",
                         i, o, x, y, res, lat, model(o, x, y));
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd33; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 10) begin
                @(negedge clk);
                op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            lat++;
        end
        checks++;
        if ({hi, lo} !== {32'd10, 32'd30} || lat != 34) begin
            errors++;
            $display("FAIL ignore_start: hi:lo=%h lat=%0d, expected %h lat=34", {hi, lo}, lat, {32'd10, 32'd30});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res;
        int lat;
        logic bsy;
        do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, res, lat, bsy);
        checks++;
        if (res !== model(2'b00, 32'h7FFF_FFFF, 32'h8000_0000) || lat != 34) begin
            errors++;
            $display("FAIL b2b_first: hi:lo=%h lat=%0d, expected %h lat=34", res, lat, model(2'b00, 32'h7FFF_FFFF, 32'h8000_0000));
        end
        // Still inside the done cycle, so this start lands on the IDLE edge.
        do_op(2'b10, 32'd12345, 32'hFFFF_FFF0, res, lat, bsy);
        checks++;
        if (res !== model(2'b10, 32'd12345, 32'hFFFF_FFF0) || lat != 34 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: hi:lo=%h lat=%0d busy=%b, expected %h lat=34 busy=0",
                     res, lat, bsy, model(2'b10, 32'd12345, 32'hFFFF_FFF0));
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] res;
        int lat;
        logic bsy;
        int seen;
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h0000_0003; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk) clrn = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
        checks++;
        if (seen != 0 || {hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_abort: done/busy cycles=%0d hi:lo=%h, expected 0 and 0", seen, {hi, lo});
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0003, res, lat, bsy);
        checks++;
        if (res !== 64'h0000_0002_FFFF_FFFD || lat != 34) begin
            errors++;
            $display("FAIL reset_recover: hi:lo=%h lat=%0d, expected 00000002fffffffd lat=34", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
